// File: rtl/beam_trigger_scaler_pkg.sv
// beam_trigger_scaler_pkg: shared defaults and saturating-increment helper for the trigger scaler
package beam_scaler_pkg;
    localparam int NBEAMS_DEF      = 48;
    localparam int COUNT_BITS_DEF  = 16;
    localparam int GATE_CYCLES_DEF = 375000;

    // Read address width. The spare code past 2*nbeams keeps out-of-range reads
    // representable even when 2*nbeams is a power of two.
    function automatic int addr_bits(input int nbeams);
        return $clog2(2 * nbeams + 1);
    endfunction

    // Increment count by inc, holding at the all-ones value of a bits-wide counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic inc, input int bits);
        logic [31:0] top;
        top = (bits >= 32) ? '1 : (32'd1 << bits) - 32'd1;
        return (inc && count != top) ? count + 32'd1 : count;
    endfunction
endpackage

// File: rtl/beam_trigger_scaler_if.sv
// beam_trigger_scaler_if: trigger input and held-count read port of the scaler
//   trigger_i    : 2*NBEAMS trigger bits, one sample per clock
//   scal_addr_i  : read address (trigger bit index)
//   scal_rd_i    : read strobe
//   scal_dat_o   : held count for the address strobed last cycle
//   scal_ack_o   : high the cycle scal_dat_o is valid
//   scal_new_o   : one-cycle pulse after the holding bank updates
//   scal_valid_o : sticky, high once a full gate has completed since reset
interface beam_trigger_scaler_if
    import beam_scaler_pkg::*;
#(
    parameter int NBEAMS     = NBEAMS_DEF,
    parameter int COUNT_BITS = COUNT_BITS_DEF
);
    localparam int ADDR_BITS = addr_bits(NBEAMS);
    logic [2*NBEAMS-1:0]   trigger_i;
    logic [ADDR_BITS-1:0]  scal_addr_i;
    logic                  scal_rd_i;
    logic [COUNT_BITS-1:0] scal_dat_o;
    logic                  scal_ack_o;
    logic                  scal_new_o;
    logic                  scal_valid_o;
    modport master (
        output trigger_i, scal_addr_i, scal_rd_i,
        input  scal_dat_o, scal_ack_o, scal_new_o, scal_valid_o
    );
    modport slave (
        input  trigger_i, scal_addr_i, scal_rd_i,
        output scal_dat_o, scal_ack_o, scal_new_o, scal_valid_o
    );
endinterface

// File: rtl/beam_trigger_scaler_counter.sv
// scaler_counter: one saturating live counter and its holding register
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i        : registered trigger bit for this counter
//   term_i       : terminal cycle of the gate
//   hold_o       : count latched at the end of the last completed gate
module scaler_counter
    import beam_scaler_pkg::*;
#(
    parameter int COUNT_BITS = COUNT_BITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    input  logic                  term_i,
    output logic [COUNT_BITS-1:0] hold_o
);
    logic [COUNT_BITS-1:0] cnt;
    logic [COUNT_BITS-1:0] nxt;

    assign nxt = COUNT_BITS'(sat_inc(32'(cnt), inc_i, COUNT_BITS));

    // The terminal-cycle sample still belongs to the closing gate, so the hold
    // register takes the incremented value while the live counter restarts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            hold_o <= '0;
        end else if (term_i) begin
            cnt    <= '0;
            hold_o <= nxt;
        end else begin
            cnt    <= nxt;
        end
    end
endmodule

// File: rtl/beam_trigger_scaler.sv
// beam_trigger_scaler: per-beam trigger rate scaler with gated counting and a registered read port
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : trigger input and read port (slave side of beam_trigger_scaler_if)
module beam_trigger_scaler
    import beam_scaler_pkg::*;
#(
    parameter int NBEAMS      = NBEAMS_DEF,
    parameter int COUNT_BITS  = COUNT_BITS_DEF,
    parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
    input logic                  clk_i,
    input logic                  rst_i,
    beam_trigger_scaler_if.slave bus
);
    localparam int NBITS     = 2 * NBEAMS;
    localparam int ADDR_BITS = addr_bits(NBEAMS);
    localparam int GW        = $clog2(GATE_CYCLES);

    logic [NBITS-1:0]      trig_q;
    logic [GW-1:0]         gate_cnt;
    logic                  term;
    logic [COUNT_BITS-1:0] hold [NBITS];
    logic [COUNT_BITS-1:0] rd_val;

    assign term = gate_cnt == GW'(GATE_CYCLES - 1);

    for (genvar i = 0; i < NBITS; i++) begin : g_cnt
        scaler_counter #(.COUNT_BITS(COUNT_BITS)) u_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .inc_i  (trig_q[i]),
            .term_i (term),
            .hold_o (hold[i])
        );
    end

    // Addresses with no matching bit fall through to zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NBITS; i++)
            rd_val = (bus.scal_addr_i == ADDR_BITS'(i)) ? hold[i] : rd_val;
    end

    // A read in the terminal cycle sees the hold bank before it updates;
    // scal_new_o tells software to read again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_q           <= '0;
            gate_cnt         <= '0;
            bus.scal_dat_o   <= '0;
            bus.scal_ack_o   <= 1'b0;
            bus.scal_new_o   <= 1'b0;
            bus.scal_valid_o <= 1'b0;
        end else begin
            trig_q           <= bus.trigger_i;
            gate_cnt         <= term ? '0 : gate_cnt + GW'(1);
            bus.scal_ack_o   <= bus.scal_rd_i;
            bus.scal_dat_o   <= bus.scal_rd_i ? rd_val : bus.scal_dat_o;
            bus.scal_new_o   <= term;
            bus.scal_valid_o <= bus.scal_valid_o | term;
        end
    end
endmodule

// File: tb/tb_beam_trigger_scaler.sv
// tb_beam_trigger_scaler: directed scoreboard bench for beam_trigger_scaler
module tb_beam_trigger_scaler;
    localparam int NB = 2;
    localparam int CB = 4;
    localparam int G  = 16;
    localparam int AB = beam_scaler_pkg::addr_bits(NB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   tg = 0;
    logic exp_valid = 1'b0;
    int   exp_q[$];
    int   n;

    always #5 clk = ~clk;

    beam_trigger_scaler_if #(.NBEAMS(NB), .COUNT_BITS(CB)) bus ();

    beam_trigger_scaler #(.NBEAMS(NB), .COUNT_BITS(CB), .GATE_CYCLES(G)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic rd_p;
        logic rst_p;
        logic en;
        int   tg_p;
        rd_p  = bus.scal_rd_i;
        rst_p = rst;
        tg_p  = tg;
        @(posedge clk);
        #1;
        en        = !rst_p && tg_p == G - 1;
        tg        = (rst_p || tg_p == G - 1) ? 0 : tg_p + 1;
        exp_valid = !rst_p && (exp_valid || en);
        chk("new", bus.scal_new_o, en);
        chk("valid", bus.scal_valid_o, exp_valid);
        chk("ack", bus.scal_ack_o, rd_p && !rst_p);
        if (rd_p && !rst_p) chk("rd_dat", bus.scal_dat_o, exp_q.pop_front());
    endtask

    task automatic read(input int a, input int e);
        bus.scal_addr_i = AB'(a);
        bus.scal_rd_i   = 1'b1;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic idle();
        bus.scal_rd_i = 1'b0;
        tick();
    endtask

    task automatic run_to(input int k);
        do tick(); while (tg != k);
    endtask

    initial begin
        bus.trigger_i   = '0;
        bus.scal_addr_i = '0;
        bus.scal_rd_i   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_dat", bus.scal_dat_o, 0);
        rst = 1'b0;
        // bit 0 for 10 samples in the first gate
        bus.trigger_i = 4'b0001;
        repeat (10) tick();
        bus.trigger_i = 4'b0000;
        run_to(0);
        read(0, 10);
        read(1, 0);
        read(2, 0);
        read(3, 0);
        idle();
        // bit 2 sampled only on the terminal cycle
        run_to(14);
        bus.trigger_i = 4'b0100;
        tick();
        bus.trigger_i = 4'b0000;
        tick();
        read(2, 1);
        idle();
        run_to(0);
        read(2, 0);
        idle();
        // bit 3 constant saturates and never wraps
        bus.trigger_i = 4'b1000;
        run_to(0);
        repeat (G) tick();
        read(3, 15);
        idle();
        run_to(0);
        read(3, 15);
        idle();
        // reset mid-gate with bit 1 active
        bus.trigger_i = 4'b0010;
        run_to(7);
        rst = 1'b1;
        tick();
        chk("rst_mid_dat", bus.scal_dat_o, 0);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.scal_new_o && n < 40);
        chk("new_latency", n, G);
        // read in the terminal cycle sees the old value, next read the new one
        bus.trigger_i = 4'b0001;
        read(1, 15);
        idle();
        tick();
        bus.trigger_i = 4'b0000;
        run_to(15);
        read(0, 0);
        read(0, 3);
        idle();
        // back-to-back reads including an out-of-range address
        read(0, 3);
        read(1, 1);
        read(2, 0);
        read(3, 0);
        read(5, 0);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
